// File: rtl/decode_issue_queue_pkg.sv
// Shared types for the decode issue queue: opcode/funct codes, ALU and writeback encodings,
// and the packed control word carried on out_ctrl.
package decode_issue_queue_pkg;

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpJal     = 6'h03;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpAddiu   = 6'h09;
  localparam logic [5:0] OpSlti    = 6'h0A;
  localparam logic [5:0] OpSltiu   = 6'h0B;
  localparam logic [5:0] OpAndi    = 6'h0C;
  localparam logic [5:0] OpOri     = 6'h0D;
  localparam logic [5:0] OpXori    = 6'h0E;
  localparam logic [5:0] OpLui     = 6'h0F;
  localparam logic [5:0] OpCop0    = 6'h10;
  localparam logic [5:0] OpLb      = 6'h20;
  localparam logic [5:0] OpLh      = 6'h21;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpLbu     = 6'h24;
  localparam logic [5:0] OpLhu     = 6'h25;
  localparam logic [5:0] OpSb      = 6'h28;
  localparam logic [5:0] OpSh      = 6'h29;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnSll     = 6'h00;
  localparam logic [5:0] FnSrl     = 6'h02;
  localparam logic [5:0] FnSra     = 6'h03;
  localparam logic [5:0] FnSllv    = 6'h04;
  localparam logic [5:0] FnSrlv    = 6'h06;
  localparam logic [5:0] FnSrav    = 6'h07;
  localparam logic [5:0] FnJr      = 6'h08;
  localparam logic [5:0] FnJalr    = 6'h09;
  localparam logic [5:0] FnSyscall = 6'h0C;
  localparam logic [5:0] FnAdd     = 6'h20;
  localparam logic [5:0] FnAddu    = 6'h21;
  localparam logic [5:0] FnSub     = 6'h22;
  localparam logic [5:0] FnSubu    = 6'h23;
  localparam logic [5:0] FnAnd     = 6'h24;
  localparam logic [5:0] FnOr      = 6'h25;
  localparam logic [5:0] FnXor     = 6'h26;
  localparam logic [5:0] FnNor     = 6'h27;
  localparam logic [5:0] FnSlt     = 6'h2A;
  localparam logic [5:0] FnSltu    = 6'h2B;
  localparam logic [5:0] FnEret    = 6'h18;

  localparam logic [4:0] Cp0Mf     = 5'h00;
  localparam logic [4:0] Cp0Mt     = 5'h04;
  localparam logic [4:0] Cp0Co     = 5'h10;

  typedef enum logic [3:0] {
    AluPlus, AluMinus, AluAnd, AluOr, AluXor, AluNor,
    AluSlt, AluSltu, AluSll, AluSrl, AluSra, AluLui
  } aluOp_e;

  typedef enum logic [1:0] {DstRt, DstRd, DstRa} regDest_e;
  typedef enum logic [1:0] {WbAlu, WbMem, WbPc8, WbCp0} wbSrc_e;
  typedef enum logic [1:0] {MemByte, MemHalf, MemWord} memLen_e;

  typedef struct packed {
    aluOp_e     aluOp;
    logic       aluSrcA;     // 1: shamt instead of rs
    logic       aluSrcB;     // 1: extended immediate instead of rt
    logic       extOp;       // 1: sign-extend immediate
    regDest_e   regDest;
    wbSrc_e     writeRegSrc;
    memLen_e    memLen;
    logic       memSigned;
    logic       readMem;
    logic       writeMem;
    logic       writeReg;
    logic       jmp;
    logic       jr;
    logic       link;
    logic       branch;
    logic       cp0Read;
    logic       cp0Write;
    logic       eret;
    logic       syscall;
    logic       illegal;
    logic [4:0] dest;        // resolved destination, 0 when nothing is written
  } ctrl_t;

  localparam int unsigned CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/decode_issue_queue_decode_core.sv
// Combinational instruction decoder: instruction word to control word plus the
// source-register usage flags needed by the load-use interlock.
module decode_issue_queue_decode_core
  import decode_issue_queue_pkg::*;
(
  input  logic [31:0] ins,
  output ctrl_t       ctrl,
  output logic        usesRs,
  output logic        usesRt
);

  logic [5:0] op;
  logic [5:0] funct;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;

  assign op    = ins[31:26];
  assign rs    = ins[25:21];
  assign rt    = ins[20:16];
  assign rd    = ins[15:11];
  assign funct = ins[5:0];

  assign usesRs = !((op == OpJ) || (op == OpJal) || (op == OpLui) || (ins == 32'h0) ||
                    ((op == OpSpecial) && ((funct == FnSll) || (funct == FnSrl) ||
                                           (funct == FnSra))));
  assign usesRt = (op == OpSpecial) || (op == OpBeq) || (op == OpBne) ||
                  (op == OpSb) || (op == OpSh) || (op == OpSw);

  always_comb begin
    ctrl = '0;
    case (op)
      OpSpecial: begin
        ctrl.regDest  = DstRd;
        ctrl.writeReg = 1'b1;
        case (funct)
          FnSll:          begin ctrl.aluOp = AluSll; ctrl.aluSrcA = 1'b1; end
          FnSrl:          begin ctrl.aluOp = AluSrl; ctrl.aluSrcA = 1'b1; end
          FnSra:          begin ctrl.aluOp = AluSra; ctrl.aluSrcA = 1'b1; end
          FnSllv:         ctrl.aluOp = AluSll;
          FnSrlv:         ctrl.aluOp = AluSrl;
          FnSrav:         ctrl.aluOp = AluSra;
          FnJr:           begin ctrl.writeReg = 1'b0; ctrl.jmp = 1'b1; ctrl.jr = 1'b1; end
          FnJalr: begin
            ctrl.jmp         = 1'b1;
            ctrl.jr          = 1'b1;
            ctrl.link        = 1'b1;
            ctrl.writeRegSrc = WbPc8;
          end
          FnSyscall:      begin ctrl.writeReg = 1'b0; ctrl.syscall = 1'b1; end
          FnAdd, FnAddu:  ctrl.aluOp = AluPlus;
          FnSub, FnSubu:  ctrl.aluOp = AluMinus;
          FnAnd:          ctrl.aluOp = AluAnd;
          FnOr:           ctrl.aluOp = AluOr;
          FnXor:          ctrl.aluOp = AluXor;
          FnNor:          ctrl.aluOp = AluNor;
          FnSlt:          ctrl.aluOp = AluSlt;
          FnSltu:         ctrl.aluOp = AluSltu;
          default:        ctrl.illegal = 1'b1;
        endcase
      end
      OpJ:   ctrl.jmp = 1'b1;
      OpJal: begin
        ctrl.jmp         = 1'b1;
        ctrl.link        = 1'b1;
        ctrl.writeReg    = 1'b1;
        ctrl.regDest     = DstRa;
        ctrl.writeRegSrc = WbPc8;
      end
      OpBeq, OpBne: begin
        ctrl.branch = 1'b1;
        ctrl.aluOp  = AluMinus;
        ctrl.extOp  = 1'b1;
      end
      OpAddi, OpAddiu, OpSlti, OpSltiu: begin
        ctrl.writeReg = 1'b1;
        ctrl.aluSrcB  = 1'b1;
        ctrl.extOp    = 1'b1;
        ctrl.aluOp    = (op == OpSlti) ? AluSlt : (op == OpSltiu) ? AluSltu : AluPlus;
      end
      OpAndi, OpOri, OpXori, OpLui: begin
        ctrl.writeReg = 1'b1;
        ctrl.aluSrcB  = 1'b1;
        ctrl.aluOp    = (op == OpAndi) ? AluAnd : (op == OpOri) ? AluOr :
                        (op == OpXori) ? AluXor : AluLui;
      end
      OpCop0: begin
        if (rs == Cp0Mf) begin
          ctrl.cp0Read     = 1'b1;
          ctrl.writeReg    = 1'b1;
          ctrl.writeRegSrc = WbCp0;
        end else if (rs == Cp0Mt) begin
          ctrl.cp0Write = 1'b1;
        end else if ((rs == Cp0Co) && (funct == FnEret)) begin
          ctrl.eret = 1'b1;
        end else begin
          ctrl.illegal = 1'b1;
        end
      end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
        ctrl.readMem     = 1'b1;
        ctrl.writeReg    = 1'b1;
        ctrl.aluSrcB     = 1'b1;
        ctrl.extOp       = 1'b1;
        ctrl.writeRegSrc = WbMem;
        ctrl.memSigned   = (op == OpLb) || (op == OpLh);
        ctrl.memLen      = (op == OpLw) ? MemWord :
                           ((op == OpLh) || (op == OpLhu)) ? MemHalf : MemByte;
      end
      OpSb, OpSh, OpSw: begin
        ctrl.writeMem = 1'b1;
        ctrl.aluSrcB  = 1'b1;
        ctrl.extOp    = 1'b1;
        ctrl.memLen   = (op == OpSw) ? MemWord : (op == OpSh) ? MemHalf : MemByte;
      end
      default: ctrl.illegal = 1'b1;
    endcase

    // An illegal instruction must have no architectural side effects downstream.
    if (ctrl.illegal) begin
      ctrl         = '0;
      ctrl.illegal = 1'b1;
    end else if (ctrl.writeReg) begin
      case (ctrl.regDest)
        DstRd:   ctrl.dest = rd;
        DstRa:   ctrl.dest = 5'd31;
        default: ctrl.dest = rt;
      endcase
    end
  end

endmodule

// File: rtl/decode_issue_queue.sv
// Buffered decoder between fetch and execute: FIFO of fetched words, decode of the head,
// registered output stage, load-use interlock, flush and sticky halt.
module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned PC_W         = 32,
  parameter bit          HALT_ON_LAST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_ins,
  input  logic [PC_W-1:0]          in_pc,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_ins,
  output logic [PC_W-1:0]          out_pc,
  output logic [CTRL_W-1:0]        out_ctrl,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     hazard_stall,
  output logic                     halted
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [31:0]     insMem [DEPTH];
  logic [PC_W-1:0] pcMem  [DEPTH];

  logic [AW:0]     wrPtr_q, wrPtr_d;
  logic [AW:0]     rdPtr_q, rdPtr_d;
  logic            outValid_q, outValid_d;
  logic [31:0]     outIns_q, outIns_d;
  logic [PC_W-1:0] outPc_q, outPc_d;
  ctrl_t           outCtrl_q, outCtrl_d;
  logic            halted_q, halted_d;

  logic            empty, full, push, free, load, hazard;
  logic [31:0]     headIns;
  logic [PC_W-1:0] headPc;
  ctrl_t           headCtrl;
  logic            headUsesRs, headUsesRt;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty     = (wrPtr_q == rdPtr_q);
  assign full      = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign occupancy = wrPtr_q - rdPtr_q;
  assign in_ready  = !full;
  assign push      = in_valid & in_ready & !flush;

  assign headIns = insMem[rdPtr_q[AW-1:0]];
  assign headPc  = pcMem[rdPtr_q[AW-1:0]];

  decode_issue_queue_decode_core uDecode (
    .ins    (headIns),
    .ctrl   (headCtrl),
    .usesRs (headUsesRs),
    .usesRt (headUsesRt)
  );

  // Staged load whose result a head source needs; holding the head one cycle lets it drain.
  assign hazard = outValid_q & outCtrl_q.readMem & outCtrl_q.writeReg &
                  (outCtrl_q.dest != 5'd0) &
                  ((headUsesRs & (headIns[25:21] == outCtrl_q.dest)) |
                   (headUsesRt & (headIns[20:16] == outCtrl_q.dest)));

  assign free         = !outValid_q | out_ready;
  assign load         = free & !empty & !hazard & !halted_q & !flush;
  assign hazard_stall = hazard & free & !empty;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (push) wrPtr_d = wrPtr_q + PtrOne;
      if (load) rdPtr_d = rdPtr_q + PtrOne;
    end
  end

  always_comb begin
    outValid_d = outValid_q;
    outIns_d   = outIns_q;
    outPc_d    = outPc_q;
    outCtrl_d  = outCtrl_q;
    halted_d   = halted_q;
    if (flush) begin
      outValid_d = 1'b0;
      halted_d   = 1'b0;
    end else if (load) begin
      outValid_d = 1'b1;
      outIns_d   = headIns;
      outPc_d    = headPc;
      outCtrl_d  = headCtrl;
      if (HALT_ON_LAST && (headIns == 32'hFFFF_FFFF)) halted_d = 1'b1;
    end else if (free) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      insMem[wrPtr_q[AW-1:0]] <= in_ins;
      pcMem[wrPtr_q[AW-1:0]]  <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      outValid_q <= 1'b0;
      outIns_q   <= '0;
      outPc_q    <= '0;
      outCtrl_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      outValid_q <= outValid_d;
      outIns_q   <= outIns_d;
      outPc_q    <= outPc_d;
      outCtrl_q  <= outCtrl_d;
      halted_q   <= halted_d;
    end
  end

  assign out_valid = outValid_q;
  assign out_ins   = outIns_q;
  assign out_pc    = outPc_q;
  assign out_ctrl  = outCtrl_q;
  assign halted    = halted_q;

endmodule
